// File: rtl/jtsdram_bank_arb_if.sv
// SDRAM read command port shared by the bank arbiter (master) and the
// SDRAM controller (slave): one outstanding read at a time.
interface jtsdram_bank_arb_if #(
    parameter int unsigned AW = 22,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] sd_addr;
    logic [1:0]    sd_ba;
    logic          sd_rd;
    logic          sd_ack;
    logic          sd_rdy;
    logic [DW-1:0] sd_dout;

    modport master (
        output sd_addr, sd_ba, sd_rd,
        input  sd_ack, sd_rdy, sd_dout
    );

    modport slave (
        input  sd_addr, sd_ba, sd_rd,
        output sd_ack, sd_rdy, sd_dout
    );
endinterface

// File: rtl/jtsdram_bank_arb.sv
// Four-bank read arbiter in front of a single-outstanding SDRAM read port.
// Round-robin by default; define JTSDRAM_FIXPRIO_EN for fixed priority
// (bank 0 highest). Refresh windows block new grants only, and a per
// transaction watchdog abandons reads that never complete.
module jtsdram_bank_arb #(
    parameter int unsigned AW   = 22,
    parameter int unsigned DW   = 32,
    parameter int unsigned TOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [4*AW-1:0]     req_addr,
    output logic [3:0]          ack,
    output logic [3:0]          rdy,
    output logic [DW-1:0]       dout,
    jtsdram_bank_arb_if.master  sd,
    input  logic                rfsh_en,
    output logic                sd_rfsh,
    output logic                busy,
    output logic                timeout
);

    localparam int unsigned WDW     = 8;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_ack;
    logic [3:0]      r_rdy;
    logic [DW-1:0]   r_dout;
    logic [AW-1:0]   r_sd_addr;
    logic [1:0]      r_sd_ba;
    logic            r_sd_rd;
    logic            r_busy;
    logic            r_timeout;
    logic [WDW-1:0]  r_wd;
`ifndef JTSDRAM_FIXPRIO_EN
    logic [1:0]      r_ptr;
    logic [1:0]      w_idx;
`endif

    logic            w_gnt_vld;
    logic [1:0]      w_gnt;
    logic [AW-1:0]   w_gnt_addr;
    logic            w_wd_hit;

    // Pick the next bank to serve from the current request vector
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 2'd0;
`ifdef JTSDRAM_FIXPRIO_EN
        // Descending scan so the lowest requesting bank wins
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = 2'(i);
            end
        end
`else
        // Descending scan from ptr+4 down to ptr+1 so ptr+1 has the last word
        w_idx = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            w_idx = r_ptr + 2'(i);
            if (req[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
`endif
    end

    // Address of the bank that would be granted this cycle
    always_comb begin
        w_gnt_addr = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_gnt == 2'(i)) begin
                w_gnt_addr = req_addr[i*AW +: AW];
            end
        end
    end

    // Watchdog fires on the TOUT-th cycle spent in CMD/WAIT
    assign w_wd_hit = (r_wd >= WD_LAST);

    // Arbiter FSM with registered command and response outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ack     <= 4'd0;
            r_rdy     <= 4'd0;
            r_dout    <= '0;
            r_sd_addr <= '0;
            r_sd_ba   <= 2'd0;
            r_sd_rd   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_wd      <= '0;
`ifndef JTSDRAM_FIXPRIO_EN
            r_ptr     <= 2'd3;
`endif
        end else begin
            r_ack <= 4'd0;
            r_rdy <= 4'd0;
            case (r_state)
                S_IDLE: begin
                    if (!rfsh_en && w_gnt_vld) begin
                        r_sd_ba   <= w_gnt;
                        r_sd_addr <= w_gnt_addr;
                        r_sd_rd   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_wd      <= '0;
`ifndef JTSDRAM_FIXPRIO_EN
                        r_ptr     <= w_gnt;
`endif
                        r_state   <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (sd.sd_ack) begin
                        r_sd_rd          <= 1'b0;
                        r_ack[r_sd_ba]   <= 1'b1;
                        r_wd             <= r_wd + WDW'(1);
                        if (sd.sd_rdy) begin
                            r_rdy[r_sd_ba] <= 1'b1;
                            r_dout         <= sd.sd_dout;
                            r_busy         <= 1'b0;
                            r_state        <= S_IDLE;
                        end else begin
                            r_state        <= S_WAIT;
                        end
                    end else if (w_wd_hit) begin
                        r_sd_rd   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd      <= r_wd + WDW'(1);
                    end
                end
                S_WAIT: begin
                    if (sd.sd_rdy) begin
                        r_rdy[r_sd_ba] <= 1'b1;
                        r_dout         <= sd.sd_dout;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end else if (w_wd_hit) begin
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd      <= r_wd + WDW'(1);
                    end
                end
                default: begin
                    r_sd_rd <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Refresh is only permitted while no transaction is in flight
    assign sd_rfsh    = rfsh_en & (r_state == S_IDLE);

    assign ack        = r_ack;
    assign rdy        = r_rdy;
    assign dout       = r_dout;
    assign busy       = r_busy;
    assign timeout    = r_timeout;
    assign sd.sd_addr = r_sd_addr;
    assign sd.sd_ba   = r_sd_ba;
    assign sd.sd_rd   = r_sd_rd;

endmodule

// File: doc/jtsdram_bank_arb.md
Name: jtsdram_bank_arb

Overview:
Round-robin arbiter that lets four bank read requesters share a single-outstanding SDRAM read command port.
- Sits between the per-bank test channels (ba0..ba3 read engines) and an SDRAM controller that accepts one read at a time.
- Holds off new grants while a refresh window is requested.
- Watchdog flags any transaction that never completes.

Parameters:
AW, 22, address width per requester and toward the SDRAM port
DW, 32, read data width
TOUT, 255, watchdog limit in clk cycles per transaction (8-bit counter; legal range 1..255)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
req  input  4  per-bank read request; level held until that bank's ack pulse
req_addr  input  4*AW  packed addresses, bank n at bits [n*AW +: AW]
ack  output  4  one-cycle pulse: bank's command accepted by SDRAM
rdy  output  4  one-cycle pulse: bank's data valid on dout
dout  output  DW  last read data, held until next rdy
sd_addr  output  AW  address of granted bank
sd_ba  output  2  granted bank number
sd_rd  output  1  read command to SDRAM controller
sd_ack  input  1  controller accepted command
sd_rdy  input  1  controller data valid on sd_dout
sd_dout  input  DW  controller read data
rfsh_en  input  1  refresh window requested
sd_rfsh  output  1  refresh permitted (arbiter idle and rfsh_en)
busy  output  1  transaction in flight
timeout  output  1  sticky watchdog error

Behaviour:
Reset (rst low at a clk edge):
- state IDLE; all outputs 0; dout 0; timeout cleared; watchdog counter 0.
- RR pointer = 3, so bank 0 is checked first.
- Applies mid-transaction: the transaction is abandoned and no ack/rdy is emitted for it.

FSM states: IDLE, CMD, WAIT.

IDLE:
- If rfsh_en=1: no grant; sd_rfsh=1 combinationally.
- Else if any req: grant the first requesting bank scanning ptr+1, ptr+2, ... (mod 4).
- On the grant edge: latch sd_ba and sd_addr, set ptr=grant, go to CMD.
- A grant edge is taken only on a cycle where rfsh_en=0.

CMD:
- sd_rd=1 and busy=1; sd_addr/sd_ba stable.
- On sd_ack: sd_rd drops the next cycle, ack[g] pulses the next cycle, go to WAIT.
- If sd_ack and sd_rdy arrive in the same cycle: ack[g] and rdy[g] both pulse the next cycle, data is latched, go to IDLE.

WAIT:
- busy=1.
- On sd_rdy: latch sd_dout into dout, pulse rdy[g] the next cycle, go to IDLE.
- sd_ack in WAIT is ignored.

Latency:
- Grant to sd_rd: 1 cycle after req seen in IDLE.
- sd_ack to ack: 1 cycle. sd_rdy to rdy: 1 cycle.
- Back-to-back: a new grant may occur on the cycle rdy pulses (IDLE re-evaluated that edge).

Requester rules:
- req dropped before grant: not served.
- req dropped after grant: the transaction still completes and ack/rdy still pulse.
- req_addr is sampled only at the grant edge.

Refresh:
- rfsh_en never interrupts CMD/WAIT; it only blocks the next grant.
- sd_rfsh = rfsh_en & (state==IDLE).

Watchdog:
- 8-bit counter, cleared on grant, increments each cycle in CMD/WAIT.
- Reaching TOUT: go to IDLE, sd_rd=0, set timeout=1 (sticky until reset), emit no ack/rdy, ptr already advanced.

Optional Feature:
JTSDRAM_FIXPRIO_EN
- Defined: fixed priority, bank 0 highest, bank 3 lowest; RR pointer unused; all other behaviour identical.
- Undefined: round-robin as above.

Test Plan:
1. Reset then req=4'b0001, addr0=22'h00_1234; sd_ack at cycle 3, sd_rdy at cycle 6 with 32'hDEAD_BEEF -> sd_rd high cycles 2-3, sd_addr=22'h001234, sd_ba=0, ack[0] pulse cycle 4, rdy[0] pulse cycle 7, dout=DEADBEEF.
2. req=4'b1111 held, controller acks/readies each command in 2 cycles -> grant order 0,1,2,3,0 with no idle gap between rdy and next sd_rd beyond 1 cycle; with JTSDRAM_FIXPRIO_EN order is 0,0,0 while req[0] held.
3. rfsh_en=1 with req=4'b0010 -> sd_rfsh=1, sd_rd=0; drop rfsh_en -> sd_rd rises 1 cycle later with sd_ba=1. rfsh_en raised during WAIT -> transaction completes first, then sd_rfsh=1.
4. Grant bank 2, never assert sd_ack -> after 255 cycles sd_rd=0, timeout=1, no ack[2]; timeout stays 1 until rst low.
5. rst low during WAIT (bank 3) then sd_rdy arrives -> no rdy pulse, dout=0, next grant goes to bank 0 if requested.
6. sd_ack and sd_rdy same cycle for bank 1 -> ack[1] and rdy[1] pulse together next cycle, state returns IDLE.
